// File: rtl/spi_flash_op_seq.sv
// rtl/spi_flash_op_seq.sv - Flash op sequencer driving an SPI flash master request port
// Expands one CPU op into WREN / main command / RDSR polling and reports done, data and timeouts.
module spi_flash_op_seq #(
   parameter int HS_TIMEOUT = 4096,
   parameter int POLL_MAX   = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [1:0]  op_code,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   output logic [31:0] op_rdata,
   output logic        op_done,
   output logic        op_error,
   output logic [31:0] spi_data_in,
   output logic [31:0] spi_address,
   output logic [7:0]  spi_command,
   output logic [2:0]  spi_commtype,
   output logic [6:0]  spi_nmiso,
   output logic [3:0]  spi_dummy,
   output logic        spi_valid,
   input  logic        spi_tready,
   input  logic [31:0] spi_data_out
);

   localparam int HS_W = $clog2(HS_TIMEOUT + 1);
   localparam int PW   = $clog2(POLL_MAX + 1);

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_PROG  = 2'd1;
   localparam logic [1:0] OP_ERASE = 2'd2;
   localparam logic [1:0] OP_RDSR  = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_BUSY, S_EVAL, S_RESP} state_t;
   typedef enum logic [1:0] {STEP_WREN, STEP_MAIN, STEP_POLL} step_t;

   state_t            r_state;
   step_t             r_step;
   logic [1:0]        r_code;
   logic [23:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_cap;
   logic [HS_W-1:0]   r_hs_cnt;
   logic [PW-1:0]     r_poll_cnt;
   logic              r_seen_idle;
   logic              r_spi_valid;
   logic [7:0]        r_spi_command;
   logic [2:0]        r_spi_commtype;
   logic [6:0]        r_spi_nmiso;
   logic [31:0]       r_spi_address;
   logic [31:0]       r_spi_data_in;
   logic [31:0]       r_op_rdata;
   logic              r_op_done;
   logic              r_op_error;

   step_t             w_lstep;
   logic [1:0]        w_lcode;
   logic [23:0]       w_laddr;
   logic [31:0]       w_lwdata;
   logic [7:0]        w_lcmd;
   logic [2:0]        w_ltype;
   logic [6:0]        w_lnmiso;
   logic              w_main_addr;
   logic              w_is_pgm;
   logic              w_wip;
   logic              w_launch;
   logic              w_hs_expired;
   logic              w_unused;

   // {command, commtype, nmiso_bits} for a step of the given op
   function automatic logic [17:0] step_fmt(input step_t s, input logic [1:0] c);
      logic [17:0] f;
      f = {8'h05, 3'b001, 7'd8};
      if (s == STEP_WREN) begin
         f = {8'h06, 3'b000, 7'd0};
      end else if (s == STEP_MAIN) begin
         case (c)
            OP_READ:  f = {8'h03, 3'b010, 7'd32};
            OP_PROG:  f = {8'h02, 3'b100, 7'd0};
            OP_ERASE: f = {8'h20, 3'b101, 7'd0};
            default:  f = {8'h05, 3'b001, 7'd8};
         endcase
      end
      return f;
   endfunction

   always_comb begin
      w_lcode  = r_code;
      w_laddr  = r_addr;
      w_lwdata = r_wdata;
      w_lstep  = (r_step == STEP_WREN) ? STEP_MAIN : STEP_POLL;
      if (r_state == S_IDLE) begin
         w_lcode  = op_code;
         w_laddr  = op_addr[23:0];
         w_lwdata = op_wdata;
         w_lstep  = (op_code == OP_PROG || op_code == OP_ERASE) ? STEP_WREN : STEP_MAIN;
      end
      {w_lcmd, w_ltype, w_lnmiso} = step_fmt(w_lstep, w_lcode);
      w_main_addr  = (w_lstep == STEP_MAIN) && (w_lcode != OP_RDSR);
      w_is_pgm     = (r_code == OP_PROG) || (r_code == OP_ERASE);
      w_wip        = r_cap[24];
      w_hs_expired = (r_hs_cnt == HS_W'(HS_TIMEOUT - 1));
      w_launch = 1'b0;
      if (r_state == S_IDLE) begin
         w_launch = op_valid;
      end else if (r_state == S_EVAL) begin
         case (r_step)
            STEP_WREN: w_launch = 1'b1;
            STEP_MAIN: w_launch = w_is_pgm;
            default:   w_launch = w_wip && (r_poll_cnt != PW'(POLL_MAX));
         endcase
      end
   end

   assign w_unused = &{1'b0, op_addr[31:24]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_step         <= STEP_WREN;
         r_code         <= '0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_cap          <= '0;
         r_hs_cnt       <= '0;
         r_poll_cnt     <= '0;
         r_seen_idle    <= 1'b0;
         r_spi_valid    <= 1'b0;
         r_spi_command  <= '0;
         r_spi_commtype <= '0;
         r_spi_nmiso    <= '0;
         r_spi_address  <= '0;
         r_spi_data_in  <= '0;
         r_op_rdata     <= '0;
         r_op_done      <= 1'b0;
         r_op_error     <= 1'b0;
      end else begin
         r_op_done  <= 1'b0;
         r_op_error <= 1'b0;
         if (w_launch) begin
            r_state        <= S_SEND;
            r_step         <= w_lstep;
            r_code         <= w_lcode;
            r_addr         <= w_laddr;
            r_wdata        <= w_lwdata;
            r_spi_valid    <= 1'b1;
            r_spi_command  <= w_lcmd;
            r_spi_commtype <= w_ltype;
            r_spi_nmiso    <= w_lnmiso;
            r_spi_address  <= w_main_addr ? {8'h00, w_laddr} : 32'h0;
            r_spi_data_in  <= (w_lstep == STEP_MAIN && w_lcode == OP_PROG) ? w_lwdata : 32'h0;
            r_hs_cnt       <= '0;
            r_seen_idle    <= 1'b0;
            if (w_lstep == STEP_POLL)
               r_poll_cnt <= (r_step == STEP_POLL) ? r_poll_cnt + PW'(1) : PW'(1);
         end else begin
            case (r_state)
               S_SEND: begin
                  // Only a tready fall seen after tready=1 counts, so a master still busy
                  // from an aborted op is not mistaken for an accept.
                  if (spi_tready)
                     r_seen_idle <= 1'b1;
                  if (r_seen_idle && !spi_tready) begin
                     r_state     <= S_BUSY;
                     r_spi_valid <= 1'b0;
                     r_hs_cnt    <= '0;
                  end else if (w_hs_expired) begin
                     r_state     <= S_IDLE;
                     r_spi_valid <= 1'b0;
                     r_op_done   <= 1'b1;
                     r_op_error  <= 1'b1;
                  end else begin
                     r_hs_cnt <= r_hs_cnt + HS_W'(1);
                  end
               end
               S_BUSY: begin
                  if (spi_tready) begin
                     r_cap   <= spi_data_out;
                     r_state <= S_EVAL;
                  end else if (w_hs_expired) begin
                     r_state    <= S_IDLE;
                     r_op_done  <= 1'b1;
                     r_op_error <= 1'b1;
                  end else begin
                     r_hs_cnt <= r_hs_cnt + HS_W'(1);
                  end
               end
               S_EVAL: begin
                  if (r_step == STEP_POLL && w_wip) begin
                     r_state    <= S_IDLE;
                     r_op_done  <= 1'b1;
                     r_op_error <= 1'b1;
                  end else begin
                     r_state   <= S_RESP;
                     r_op_done <= 1'b1;
                     if (r_code == OP_READ)
                        r_op_rdata <= r_cap;
                     else if (r_code == OP_RDSR)
                        r_op_rdata <= {24'h0, r_cap[31:24]};
                  end
               end
               S_RESP:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign op_ready     = (r_state == S_IDLE);
   assign op_rdata     = r_op_rdata;
   assign op_done      = r_op_done;
   assign op_error     = r_op_error;
   assign spi_data_in  = r_spi_data_in;
   assign spi_address  = r_spi_address;
   assign spi_command  = r_spi_command;
   assign spi_commtype = r_spi_commtype;
   assign spi_nmiso    = r_spi_nmiso;
   assign spi_dummy    = 4'd0;
   assign spi_valid    = r_spi_valid;

endmodule
